// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter with a one-entry holding buffer.
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, 1 or 2 stop bits.
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  in_ready,
  output logic                  tx_serial,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d);
    return (^d) ^ 1'(PARITY_ODD);
  endfunction

  state_t                  state_r, state_s;
  logic [DATA_WIDTH-1:0]   shift_r, shift_s;
  logic [CNT_W-1:0]        bit_cnt_r, bit_cnt_s;
  logic                    stop_cnt_r, stop_cnt_s;
  logic                    parity_r, parity_s;
  logic                    tx_serial_r, tx_serial_s;
  logic                    tx_done_r, tx_done_s;
  logic [DATA_WIDTH-1:0]   buf_r;
  logic                    buf_valid_r;
  logic                    load_s;

  assign in_ready  = !buf_valid_r;
  assign tx_busy   = (state_r != IDLE) || buf_valid_r;
  assign tx_serial = tx_serial_r;
  assign tx_done   = tx_done_r;

  // Next-state and next-line logic; everything advances only on baud_tick.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    bit_cnt_s   = bit_cnt_r;
    stop_cnt_s  = stop_cnt_r;
    parity_s    = parity_r;
    tx_serial_s = tx_serial_r;
    tx_done_s   = 1'b0;
    load_s      = 1'b0;
    if (baud_tick) begin
      case (state_r)
        IDLE: begin
          if (buf_valid_r) begin
            load_s      = 1'b1;
            shift_s     = buf_r;
            parity_s    = parity_bit(buf_r);
            tx_serial_s = 1'b0;
            state_s     = START;
          end else begin
            tx_serial_s = 1'b1;
            state_s     = IDLE;
          end
        end
        START: begin
          tx_serial_s = shift_r[0];
          shift_s     = shift_r >> 1;
          bit_cnt_s   = '0;
          state_s     = DATA;
        end
        DATA: begin
          if (int'(bit_cnt_r) < DATA_WIDTH - 1) begin
            tx_serial_s = shift_r[0];
            shift_s     = shift_r >> 1;
            bit_cnt_s   = bit_cnt_r + CNT_W'(1);
          end else if (PARITY_EN != 0) begin
            tx_serial_s = parity_r;
            state_s     = PARITY;
          end else begin
            tx_serial_s = 1'b1;
            stop_cnt_s  = 1'b0;
            state_s     = STOP;
          end
        end
        PARITY: begin
          tx_serial_s = 1'b1;
          stop_cnt_s  = 1'b0;
          state_s     = STOP;
        end
        STOP: begin
          if (int'(stop_cnt_r) < STOP_BITS - 1) begin
            stop_cnt_s  = stop_cnt_r + 1'b1;
            tx_serial_s = 1'b1;
          end else begin
            tx_done_s = 1'b1;
            // A queued byte starts immediately so frames run back to back.
            if (buf_valid_r) begin
              load_s      = 1'b1;
              shift_s     = buf_r;
              parity_s    = parity_bit(buf_r);
              tx_serial_s = 1'b0;
              state_s     = START;
            end else begin
              tx_serial_s = 1'b1;
              state_s     = IDLE;
            end
          end
        end
        default: begin
          tx_serial_s = 1'b1;
          state_s     = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Frame state, shift register, counters and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      shift_r     <= '0;
      bit_cnt_r   <= '0;
      stop_cnt_r  <= 1'b0;
      parity_r    <= 1'b0;
      tx_serial_r <= 1'b1;
      tx_done_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      bit_cnt_r   <= bit_cnt_s;
      stop_cnt_r  <= stop_cnt_s;
      parity_r    <= parity_s;
      tx_serial_r <= tx_serial_s;
      tx_done_r   <= tx_done_s;
    end
  end

  // Holding buffer: an unload and a handshake never coincide since in_ready is low while full.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_r <= 1'b0;
      buf_r       <= '0;
    end else if (load_s) begin
      buf_valid_r <= 1'b0;
    end else if (in_valid && !buf_valid_r) begin
      buf_valid_r <= 1'b1;
      buf_r       <= data_in;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations share stimulus; a behavioural receiver decodes each line.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       in_valid;
  logic [7:0] data_in;
  logic [2:0] in_ready, ser, busy, done;

  int checks = 0;
  int errors = 0;
  int tick_div = 16;
  int tick_cnt = 0;
  logic tick_q = 1'b0;
  logic rst_q = 1'b1;

  bit          raw_q[3][$];
  byte unsigned exp_q[3][$];
  int          start_q[3][$];
  int          dec_pos[3]    = '{-1, -1, -1};
  logic [7:0]  dec_acc[3];
  int          dec_frames[3] = '{0, 0, 0};
  int          done_cnt[3]   = '{0, 0, 0};

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_valid(in_valid), .data_in(data_in),
    .in_ready(in_ready[0]), .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_valid(in_valid), .data_in(data_in),
    .in_ready(in_ready[1]), .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_valid(in_valid), .data_in(data_in),
    .in_ready(in_ready[2]), .tx_serial(ser[2]), .tx_busy(busy[2]), .tx_done(done[2]));

  function automatic int cfg_pe(input int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic logic cfg_po(input int k);
    return (k == 1) ? 1'b1 : 1'b0;
  endfunction

  function automatic int cfg_sb(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int k);
    return 1 + 8 + cfg_pe(k) + cfg_sb(k);
  endfunction

  // Bit i of the result is the line level during the i-th baud period of the frame.
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int k);
    logic [15:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1 + i] = d[i];
    if (cfg_pe(k) == 1) b[9] = (^d) ^ cfg_po(k);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Baud tick source: one pulse every tick_div clocks, or continuous when tick_div <= 1.
  initial begin
    int c;
    c = 0;
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_div <= 1) begin
        baud_tick = 1'b1;
        c = 0;
      end else begin
        c = (c + 1 >= tick_div) ? 0 : c + 1;
        baud_tick = (c == 0);
      end
    end
  end

  always @(posedge clk) begin
    tick_q <= baud_tick;
    rst_q  <= rst;
    if (baud_tick) tick_cnt <= tick_cnt + 1;
  end

  // Receiver model: samples each line once per baud period and checks frames and tx_done timing.
  always @(negedge clk) begin : monitor
    logic b;
    int   p;
    int   s;
    for (int k = 0; k < 3; k++) begin
      if (done[k]) begin
        done_cnt[k]++;
        if (start_q[k].size() > 0) begin
          s = start_q[k].pop_front();
          chk("done_ticks", tick_cnt - s, frame_len(k));
        end else begin
          chk("done_unexpected", 32'd0, 32'd1);
        end
      end
      if (rst_q) begin
        dec_pos[k] = -1;
        start_q[k].delete();
      end else if (tick_q) begin
        b = ser[k];
        raw_q[k].push_back(b);
        if (dec_pos[k] < 0) begin
          if (!b) begin
            dec_pos[k] = 1;
            start_q[k].push_back(tick_cnt);
          end
        end else begin
          p = dec_pos[k];
          if (p <= 8) dec_acc[k][p - 1] = b;
          else if (cfg_pe(k) == 1 && p == 9) chk("parity_bit", 32'(b), 32'((^dec_acc[k]) ^ cfg_po(k)));
          else chk("stop_bit", 32'(b), 32'd1);
          dec_pos[k] = p + 1;
          if (dec_pos[k] == frame_len(k)) begin
            dec_pos[k] = -1;
            dec_frames[k]++;
            if (exp_q[k].size() > 0) chk("rx_data", 32'(dec_acc[k]), 32'(exp_q[k].pop_front()));
            else chk("rx_unexpected", 32'd0, 32'd1);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    data_in  = d;
    while (!in_ready[0] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 32'(in_ready[0]), 32'd1);
    if (in_ready[0]) for (int k = 0; k < 3; k++) exp_q[k].push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
    data_in  = 8'($urandom);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done[0] && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done[0]), 32'd1);
  endtask

  task automatic check_raw(input int k, input logic [7:0] d0, input logic [7:0] d1,
                           input int nfr, input string tag);
    logic [31:0] obs, expv;
    logic [15:0] fb;
    int len, idx;
    obs = '1; expv = '1; len = frame_len(k); idx = 0;
    while (raw_q[k].size() > 0 && raw_q[k][0] == 1'b1) void'(raw_q[k].pop_front());
    for (int f = 0; f < nfr; f++) begin
      fb = frame_bits((f == 0) ? d0 : d1, k);
      for (int i = 0; i < len; i++) begin
        expv[idx] = fb[i];
        if (raw_q[k].size() > 0) obs[idx] = raw_q[k].pop_front();
        else obs[idx] = 1'bx;
        idx++;
      end
    end
    chk(tag, obs, expv);
  endtask

  task automatic clear_raw();
    for (int k = 0; k < 3; k++) raw_q[k].delete();
  endtask

  initial begin
    int n, first, d0, base;
    logic ok;
    logic [7:0] rb;
    rst = 1'b1; in_valid = 1'b0; data_in = 8'h00; tick_div = 16;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_serial_%0d", k), 32'(ser[k]), 32'd1);
      chk($sformatf("reset_ready_%0d", k), 32'(in_ready[k]), 32'd1);
      chk($sformatf("reset_busy_%0d", k), 32'(busy[k]), 32'd0);
      chk($sformatf("reset_done_%0d", k), 32'(done[k]), 32'd0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single frames: 0xA5 then 0x01 in all three configurations.
    clear_raw();
    send(8'hA5);
    wait_done(400);
    for (int k = 0; k < 3; k++) chk($sformatf("a5_busy_fall_%0d", k), 32'(busy[k]), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_raw(k, 8'hA5, 8'h00, 1, $sformatf("a5_line_%0d", k));
    clear_raw();
    send(8'h01);
    wait_done(400);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_raw(k, 8'h01, 8'h00, 1, $sformatf("x01_line_%0d", k));

    // Back-to-back 0x00 then 0xFF with no idle gap.
    clear_raw();
    send(8'h00);
    send(8'hFF);
    ok = 1'b1; n = 0;
    while (!done[0] && n < 1000) begin
      if (in_ready[0]) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("b2b_ready_low", 32'(ok), 32'd1);
    chk("b2b_first_done", 32'(done[0]), 32'd1);
    chk("b2b_ready_after_load", 32'(in_ready[0]), 32'd1);
    chk("b2b_busy_held", 32'(busy[0]), 32'd1);
    first = tick_cnt;
    @(negedge clk);
    wait_done(1000);
    chk("b2b_done_spacing", tick_cnt - first, 32'd11);
    chk("b2b_busy_fall", 32'(busy[0]), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_raw(k, 8'h00, 8'hFF, 2, $sformatf("b2b_line_%0d", k));

    // Reset in the middle of the fourth data bit of 0x3C.
    clear_raw();
    send(8'h3C);
    n = 0;
    while (dec_pos[0] != 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_bit3", dec_pos[0], 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst_serial_%0d", k), 32'(ser[k]), 32'd1);
      chk($sformatf("midrst_ready_%0d", k), 32'(in_ready[k]), 32'd1);
      chk($sformatf("midrst_busy_%0d", k), 32'(busy[k]), 32'd0);
      chk($sformatf("midrst_done_%0d", k), 32'(done[k]), 32'd0);
      exp_q[k].delete();
    end
    d0 = done_cnt[0];
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (!ser[0]) ok = 1'b0;
    end
    chk("midrst_line_high", 32'(ok), 32'd1);
    chk("midrst_no_done", done_cnt[0], d0);
    clear_raw();
    send(8'h3C);
    wait_done(400);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_raw(k, 8'h3C, 8'h00, 1, $sformatf("after_rst_line_%0d", k));

    // baud_tick held high: one bit per clock.
    tick_div = 1;
    repeat (3) @(negedge clk);
    clear_raw();
    rb = 8'($urandom);
    send(rb);
    wait_done(100);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check_raw(k, rb, 8'h00, 1, $sformatf("cont_tick_line_%0d", k));

    // Loopback: 256 random bytes with random gaps.
    tick_div = 4;
    base = dec_frames[0];
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      send(8'($urandom));
    end
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    chk("loopback_count", dec_frames[0] - base, 32'd256);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("all_decoded_%0d", k), exp_q[k].size(), 32'd0);
      chk($sformatf("done_vs_frames_%0d", k), done_cnt[k], dec_frames[k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
